// File: rtl/seg_stopwatch_bcd.sv
// Four-digit BCD stopwatch (SS.hh) with debounced start/lap/clear buttons and
// registered active-low 7-segment patterns for the downstream scan driver.
module seg_stopwatch_bcd #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_n,
  input  logic       btn_lap_n,
  input  logic       btn_clr_n,
  output logic [7:0] seg3,
  output logic [7:0] seg2,
  output logic [7:0] seg1,
  output logic [7:0] seg0,
  output logic       running,
  output logic       lap_active,
  output logic       wrapped
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam logic [PreW-1:0] PreLast = PreW'(Div - 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  // Button index: 0 start, 1 lap, 2 clear.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q, deb_q, ev_q;
  logic [DebW-1:0] deb_cnt_q [3];

  assign btn_raw = {btn_clr_n, btn_lap_n, btn_start_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      ev_q    <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        ev_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          deb_cnt_q[i] <= '0;
          deb_q[i]     <= sync2_q[i];
          ev_q[i]      <= ~sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  state_e             state_q;
  logic [3:0][3:0]    cnt_q, lap_q, cnt_inc, disp;
  logic [PreW-1:0]    presc_q;
  logic               do_start, do_lap, do_clr, counting, tick, carry;

  // Only the highest-priority event survives: clear > start > lap.
  assign do_clr   = ev_q[2];
  assign do_start = ev_q[0] & ~ev_q[2];
  assign do_lap   = ev_q[1] & ~ev_q[0] & ~ev_q[2];
  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PreLast);
  assign disp     = (state_q == StLap) ? lap_q : cnt_q;

  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lap_q      <= '0;
      presc_q    <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrapped    <= 1'b0;
      seg3       <= 8'hC0;
      seg2       <= 8'h40;
      seg1       <= 8'hC0;
      seg0       <= 8'hC0;
    end else begin
      if (counting) begin
        if (tick) begin
          presc_q <= '0;
          cnt_q   <= cnt_inc;
          if (carry) wrapped <= 1'b1;
        end else begin
          presc_q <= presc_q + PreW'(1);
        end
      end

      seg3 <= seg_decode(disp[3]);
      seg2 <= seg_decode(disp[2]) & 8'h7F;
      seg1 <= seg_decode(disp[1]);
      seg0 <= seg_decode(disp[0]);

      unique case (state_q)
        StIdle: begin
          if (do_start) begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end
        StRun: begin
          if (do_start) begin
            state_q <= StPause;
            running <= 1'b0;
          end else if (do_lap) begin
            state_q    <= StLap;
            lap_q      <= cnt_q;
            lap_active <= 1'b1;
          end
        end
        StLap: begin
          if (do_start) begin
            state_q    <= StPause;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (do_lap) begin
            state_q    <= StRun;
            lap_active <= 1'b0;
          end
        end
        StPause: begin
          if (do_clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            presc_q <= '0;
            wrapped <= 1'b0;
          end else if (do_start) begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
